pid_sequencer: RTL and testbench

//  Sequences one PID update per sample tick: latches setpoint/measurement, computes the error,

---
 rtl/pid_pkg.sv | 29 ++
 rtl/pid_term_mul.sv | 29 ++
 rtl/pid_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pid_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared types and constants for the PID sequencer
//
// Purpose: sequencer state encoding, config register addresses and the
// datapath widths shared by pid_sequencer and pid_term_mul.
// Ports: none (package).

package pid_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    TERM_P = 3'd2,
    TERM_I = 3'd3,
    TERM_D = 3'd4,
    OUT    = 3'd5
  } pid_state_t;

  localparam logic [1:0] CFG_KP   = 2'd0;
  localparam logic [1:0] CFG_KI   = 2'd1;
  localparam logic [1:0] CFG_KD   = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

  // error is the difference of two unsigned bytes, derivative is the
  // difference of two errors, product is byte gain times derivative
  localparam int E_W    = 9;
  localparam int DE_W   = 10;
  localparam int PROD_W = 18;

endpackage

// File: rtl/pid_term_mul.sv
// rtl/pid_term_mul.sv - shared gain x operand multiplier for the PID terms
//
// Purpose: combinational unsigned 8-bit gain times signed 10-bit operand,
// giving a signed 18-bit product. The sequencer reuses this one multiplier
// for the P, I and D terms on successive cycles.
// Ports:
//   gain     in   8       unsigned gain
//   operand  in   DE_W    signed error or error delta
//   prod     out  PROD_W  signed product

module pid_term_mul
  import pid_pkg::*;
(
  input  logic        [7:0]        gain,
  input  logic signed [DE_W-1:0]   operand,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] operand_ext;

  // gain is unsigned: zero-extend so it never reads as negative
  assign gain_ext    = {{(PROD_W-8){1'b0}}, gain};
  assign operand_ext = {{(PROD_W-DE_W){operand[DE_W-1]}}, operand};

  // 255 * +/-510 fits comfortably inside 18 signed bits
  assign prod = gain_ext * operand_ext;

endmodule

// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - one PID update per sample tick on a shared multiplier
//
// Purpose: latches setpoint/measurement on an accepted tick, forms the
// error and its delta, evaluates P, I and D one term per cycle on a single
// multiplier, sums, scales by SHIFT and clamps to an 8-bit actuator value.
// Gains live in a byte-wide register file; a shadow copy taken at tick
// acceptance keeps an in-flight update consistent with mid-run writes.
// Ports:
//   clk        in   1  clock
//   rst_n      in   1  asynchronous active-low reset
//   tick       in   1  start-of-sample strobe
//   setpoint   in   8  unsigned target
//   meas       in   8  unsigned measurement
//   cfg_we     in   1  config write strobe
//   cfg_addr   in   2  0=kp 1=ki 2=kd 3=ctrl
//   cfg_data   in   8  config write data
//   out        out  8  actuator value, held between updates
//   out_valid  out  1  pulse when out updates
//   busy       out  1  update in progress
//   overrun    out  1  sticky: tick dropped while busy

module pid_sequencer
  import pid_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] setpoint,
  input  logic [7:0] meas,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int SUM_W = ACC_W + 3;

  pid_state_t state, state_nxt;

  logic [7:0] kp, ki, kd;
  logic [7:0] kp_s, ki_s, kd_s;
  logic [7:0] sp_q, meas_q;

  logic signed [E_W-1:0]    e_q, e_prev;
  logic signed [DE_W-1:0]   de_q;
  logic                     first;
  logic signed [PROD_W-1:0] p_q;
  logic signed [ACC_W-1:0]  integ;
  logic [7:0]               out_q;
  logic                     overrun_q;

  logic accept, tick_drop;
  logic clr_integ, clr_ovr;

  logic        [7:0]        mul_gain;
  logic signed [DE_W-1:0]   mul_op;
  logic signed [PROD_W-1:0] prod;

  logic signed [E_W-1:0]    e_calc;
  logic signed [DE_W-1:0]   de_calc;
  logic signed [SUM_W-1:0]  i_sum;
  logic [SUM_W-ACC_W:0]     i_upper;
  logic signed [ACC_W-1:0]  integ_sat;
  logic signed [SUM_W-1:0]  t_sum;
  logic signed [SUM_W-1:0]  y;
  logic [7:0]               y_clamp;

  assign accept    = (state == IDLE) && tick;
  assign tick_drop = (state != IDLE) && tick;
  assign clr_integ = cfg_we && (cfg_addr == CFG_CTRL) && cfg_data[0];
  assign clr_ovr   = cfg_we && (cfg_addr == CFG_CTRL) && cfg_data[1];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick) state_nxt = ERR;
      ERR:     state_nxt = TERM_P;
      TERM_P:  state_nxt = TERM_I;
      TERM_I:  state_nxt = TERM_D;
      TERM_D:  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------- shared multiplier
  always_comb begin
    mul_gain = kp_s;
    mul_op   = {e_q[E_W-1], e_q};
    unique case (state)
      TERM_I: mul_gain = ki_s;
      TERM_D: begin
        mul_gain = kd_s;
        mul_op   = de_q;
      end
      default: ;
    endcase
  end

  pid_term_mul u_mul (
    .gain    (mul_gain),
    .operand (mul_op),
    .prod    (prod)
  );

  // ------------------------------------------------------------ datapath
  assign e_calc  = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
  assign de_calc = {e_calc[E_W-1], e_calc} - {e_prev[E_W-1], e_prev};

  // integrator: widen, add, then clamp back to ACC_W if the bits above the
  // ACC_W sign position disagree with the sign
  assign i_sum   = {{(SUM_W-ACC_W){integ[ACC_W-1]}}, integ}
                 + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign i_upper = i_sum[SUM_W-1:ACC_W-1];

  always_comb begin
    integ_sat = i_sum[ACC_W-1:0];
    if (!((i_upper == '0) || (i_upper == '1))) begin
      if (i_sum[SUM_W-1]) integ_sat = {1'b1, {(ACC_W-1){1'b0}}};
      else                integ_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // final sum is formed in TERM_D with d taken straight off the multiplier,
  // so out is registered on entry to OUT and lines up with out_valid
  assign t_sum = {{(SUM_W-PROD_W){p_q[PROD_W-1]}}, p_q}
               + {{(SUM_W-ACC_W){integ[ACC_W-1]}}, integ}
               + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign y = t_sum >>> SHIFT;

  always_comb begin
    y_clamp = y[7:0];
    if (y[SUM_W-1])          y_clamp = 8'd0;
    else if (|y[SUM_W-2:8])  y_clamp = 8'd255;
  end

  // ------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp        <= '0;
      ki        <= '0;
      kd        <= '0;
      kp_s      <= '0;
      ki_s      <= '0;
      kd_s      <= '0;
      sp_q      <= '0;
      meas_q    <= '0;
      e_q       <= '0;
      e_prev    <= '0;
      de_q      <= '0;
      first     <= 1'b1;
      p_q       <= '0;
      integ     <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (cfg_we) begin
        unique case (cfg_addr)
          CFG_KP:  kp <= cfg_data;
          CFG_KI:  ki <= cfg_data;
          CFG_KD:  kd <= cfg_data;
          default: ;
        endcase
      end

      // the shadow gains see the live registers as they were before any
      // write landing in the same cycle as the tick
      if (accept) begin
        sp_q   <= setpoint;
        meas_q <= meas;
        kp_s   <= kp;
        ki_s   <= ki;
        kd_s   <= kd;
      end

      unique case (state)
        ERR: begin
          e_q  <= e_calc;
          de_q <= first ? '0 : de_calc;
        end
        TERM_P: p_q   <= prod;
        TERM_I: integ <= integ_sat;
        TERM_D: out_q <= y_clamp;
        OUT: begin
          e_prev <= e_q;
          first  <= 1'b0;
        end
        default: ;
      endcase

      // placed after the state updates so a clear beats a coincident
      // integrator update or first-sample retirement
      if (clr_integ) begin
        integ <= '0;
        first <= 1'b1;
      end

      if (tick_drop)    overrun_q <= 1'b1;
      else if (clr_ovr) overrun_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// tb/tb_pid_sequencer.sv - directed self-checking bench for pid_sequencer

module tb_pid_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] setpoint = 8'd0;
  logic [7:0] meas = 8'd0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  integer total = 0;
  integer bad = 0;

  logic [7:0] r_out;
  integer     r_lat, r_busy, r_nval;
  integer     nv;

  always #5 clk = ~clk;

  pid_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .setpoint  (setpoint),
    .meas      (meas),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input integer obs, input integer exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // one tick, then 12 observed cycles; optionally a second tick and/or a
  // kp write injected at a chosen cycle k after the tick
  task automatic run(input logic [7:0] sp, input logic [7:0] m,
                     input integer inj_tick, input integer inj_kp,
                     input logic [7:0] kp_val);
    @(negedge clk);
    setpoint = sp; meas = m; tick = 1'b1;
    r_out = 'x; r_lat = -1; r_busy = 0; r_nval = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tick     = (k == inj_tick);
      cfg_we   = (k == inj_kp);
      cfg_addr = 2'd0;
      cfg_data = kp_val;
      if (busy) r_busy = r_busy + 1;
      if (out_valid) begin
        r_nval = r_nval + 1;
        if (r_lat < 0) begin
          r_lat = k;
          r_out = out;
        end
      end
    end
    tick = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // 1: proportional only
    cfg(2'd0, 8'd16);
    run(8'd100, 8'd60, 0, 0, 8'd0);
    check("t1_out", r_out, 40);
    check("t1_latency", r_lat, 5);
    check("t1_busy_cycles", r_busy, 5);
    check("t1_npulse", r_nval, 1);

    // 2: clamps
    run(8'd10, 8'd50, 0, 0, 8'd0);
    check("t2_low_clamp", r_out, 0);
    cfg(2'd0, 8'd255);
    run(8'd200, 8'd0, 0, 0, 8'd0);
    check("t2_high_clamp", r_out, 255);

    // 3: integral accumulate and saturate
    cfg(2'd0, 8'd0);
    cfg(2'd1, 8'd8);
    cfg(2'd3, 8'h01);
    run(8'd1, 8'd0, 0, 0, 8'd0);
    check("t3_i1", r_out, 0);
    run(8'd1, 8'd0, 0, 0, 8'd0);
    check("t3_i2", r_out, 1);
    run(8'd1, 8'd0, 0, 0, 8'd0);
    check("t3_i3", r_out, 1);
    run(8'd1, 8'd0, 0, 0, 8'd0);
    check("t3_i4", r_out, 2);
    cfg(2'd1, 8'd255);
    run(8'd255, 8'd0, 0, 0, 8'd0);
    check("t3_sat", r_out, 255);

    // 4: derivative, first sample suppressed
    cfg(2'd1, 8'd0);
    cfg(2'd2, 8'd16);
    cfg(2'd3, 8'h01);
    run(8'd40, 8'd0, 0, 0, 8'd0);
    check("t4_first", r_out, 0);
    run(8'd50, 8'd0, 0, 0, 8'd0);
    check("t4_de10", r_out, 10);

    // 5: overrun and shadowed gains
    cfg(2'd2, 8'd0);
    cfg(2'd0, 8'd16);
    cfg(2'd3, 8'h01);
    run(8'd100, 8'd60, 3, 0, 8'd0);
    check("t5_ovr_out", r_out, 40);
    check("t5_ovr_npulse", r_nval, 1);
    check("t5_ovr_set", overrun, 1);
    cfg(2'd3, 8'h02);
    check("t5_ovr_clr", overrun, 0);
    run(8'd100, 8'd60, 0, 2, 8'd32);
    check("t5_old_kp", r_out, 40);
    run(8'd100, 8'd60, 0, 0, 8'd0);
    check("t5_new_kp", r_out, 80);
    run(8'd100, 8'd60, 5, 0, 8'd0);
    check("t5_b2b_ovr", overrun, 1);
    check("t5_b2b_npulse", r_nval, 1);
    cfg(2'd3, 8'h02);
    run(8'd100, 8'd60, 6, 0, 8'd0);
    check("t5_next_npulse", r_nval, 2);
    check("t5_next_noovr", overrun, 0);

    // 6: reset in TERM_I aborts the update
    cfg(2'd0, 8'd0);
    cfg(2'd1, 8'd16);
    cfg(2'd3, 8'h01);
    run(8'd16, 8'd0, 0, 0, 8'd0);
    check("t6_pre", r_out, 16);
    @(negedge clk);
    setpoint = 8'd16; meas = 8'd0; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_out", out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", out_valid, 0);
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (out_valid) nv = nv + 1;
    end
    check("t6_no_pulse", nv, 0);
    cfg(2'd1, 8'd16);
    cfg(2'd2, 8'd16);
    run(8'd32, 8'd0, 0, 0, 8'd0);
    check("t6_after", r_out, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
